// File: rtl/cmp_minmax_seq.sv
// Streams LEN unsigned words through an external registered magnitude comparator and
// reports the running max/min with their first-occurrence indices.
//
// state   | meaning
// IDLE    | waiting for start
// FIRST   | accept word 0, seed max/min
// NEXT    | accept next word into cur, present cur vs max to comparator
// CMP_MAX | comparator samples cur vs max
// CHK_MAX | max flags valid, present cur vs min to comparator
// CMP_MIN | comparator samples cur vs min
// CHK_MIN | min flags valid, advance word counter
// DONE    | one-cycle completion pulse
module cmp_minmax_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  input  logic             cmp_l,
  input  logic             cmp_g,
  input  logic             cmp_e,
  output logic             busy,
  output logic             done,
  output logic             empty,
  output logic [31:0]      max_val,
  output logic [31:0]      min_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] min_idx
);

  typedef enum logic [2:0] {
    IDLE, FIRST, CMP_MAX, CHK_MAX, CMP_MIN, CHK_MIN, NEXT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      cur_q, cur_d;
  logic [31:0]      max_q, max_d;
  logic [31:0]      min_q, min_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d;
  logic [CNT_W-1:0] min_idx_q, min_idx_d;
  logic [31:0]      cmp_a_q, cmp_a_d;
  logic [31:0]      cmp_b_q, cmp_b_d;
  logic             empty_q, empty_d;

  // Only a clean one-hot flag set is trusted to update the extrema.
  logic g_only, l_only;
  assign g_only = cmp_g & ~cmp_l & ~cmp_e;
  assign l_only = cmp_l & ~cmp_g & ~cmp_e;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    cur_d     = cur_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    cmp_a_d   = cmp_a_q;
    cmp_b_d   = cmp_b_q;
    empty_d   = empty_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_d   = DONE;
            empty_d   = 1'b1;
            max_d     = '0;
            min_d     = '0;
            max_idx_d = '0;
            min_idx_d = '0;
          end else begin
            state_d = FIRST;
            len_d   = len;
            cnt_d   = '0;
            empty_d = 1'b0;
          end
        end
      end
      FIRST: begin
        if (in_valid) begin
          max_d     = in_data;
          min_d     = in_data;
          max_idx_d = '0;
          min_idx_d = '0;
          cnt_d     = CNT_W'(1);
          state_d   = (len_q == CNT_W'(1)) ? DONE : NEXT;
        end
      end
      NEXT: begin
        // Operands are registered here so they are stable throughout CMP_MAX.
        if (in_valid) begin
          cur_d   = in_data;
          cmp_a_d = in_data;
          cmp_b_d = max_q;
          state_d = CMP_MAX;
        end
      end
      CMP_MAX: state_d = CHK_MAX;
      CHK_MAX: begin
        if (g_only) begin
          max_d     = cur_q;
          max_idx_d = cnt_q;
        end
        cmp_a_d = cur_q;
        cmp_b_d = min_q;
        state_d = CMP_MIN;
      end
      CMP_MIN: state_d = CHK_MIN;
      CHK_MIN: begin
        if (l_only) begin
          min_d     = cur_q;
          min_idx_d = cnt_q;
        end
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q + CNT_W'(1) == len_q) ? DONE : NEXT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      cmp_a_q   <= '0;
      cmp_b_q   <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      cmp_a_q   <= cmp_a_d;
      cmp_b_q   <= cmp_b_d;
      empty_q   <= empty_d;
    end
  end

  assign in_ready = (state_q == FIRST) || (state_q == NEXT);
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign empty    = empty_q;
  assign cmp_a    = cmp_a_q;
  assign cmp_b    = cmp_b_q;
  assign max_val  = max_q;
  assign min_val  = min_q;
  assign max_idx  = max_idx_q;
  assign min_idx  = min_idx_q;

endmodule
